// File: rtl/mat_solve.sv
// Sequential 2x2 signed matrix solver: B = adj(A)*C / det(A).
// One shared 32x32 multiplier and one 64-iteration restoring divider,
// time-multiplexed by a single FSM.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE, and B and
// the flags stay stable while out_valid && !out_ready.
module mat_solve #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*W-1:0] A,
  input  logic [4*W-1:0] C,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] B,
  output logic           singular,
  output logic           inexact,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_DET0, S_DET1, S_CHK, S_MUL0, S_MUL1, S_DIV, S_DONE
  } state_t;

  state_t                state;
  logic [4*W-1:0]        a_q, c_q, res;
  logic signed [2*W-1:0] det, num;
  logic [2*W-1:0]        dabs, quo, rem;
  logic                  d_neg, n_neg, inx_acc;
  logic [5:0]            cnt;
  logic [1:0]            el;

  logic signed [W-1:0]   a00, a01, a10, a11, c00, c01, c10, c11;
  logic signed [W-1:0]   op_x, op_y;
  logic signed [2*W-1:0] prod, num_nx;
  logic [2*W:0]          trial;
  logic                  q_bit;
  logic [2*W-1:0]        rem_nx, quo_nx;
  logic [W-1:0]          b_word;
  logic [4*W-1:0]        res_nx;

  assign {a00, a01, a10, a11} = a_q;
  assign {c00, c01, c10, c11} = c_q;
  assign dbg_state = state;

  // Operand select for the shared multiplier: determinant terms, then the
  // two adjugate products of the current element's numerator.
  always_comb begin
    op_x = a00;
    op_y = a11;
    case (state)
      S_DET1: begin op_x = a01; op_y = a10; end
      S_MUL0: begin
        case (el)
          2'd0:    begin op_x = a11; op_y = c00; end
          2'd1:    begin op_x = a11; op_y = c01; end
          2'd2:    begin op_x = a00; op_y = c10; end
          default: begin op_x = a00; op_y = c11; end
        endcase
      end
      S_MUL1: begin
        case (el)
          2'd0:    begin op_x = a01; op_y = c10; end
          2'd1:    begin op_x = a01; op_y = c11; end
          2'd2:    begin op_x = a10; op_y = c00; end
          default: begin op_x = a10; op_y = c01; end
        endcase
      end
      default: begin op_x = a00; op_y = a11; end
    endcase
  end

  assign prod   = $signed({{W{op_x[W-1]}}, op_x}) * $signed({{W{op_y[W-1]}}, op_y});
  assign num_nx = num - prod;

  // One restoring-division step on magnitudes; the remainder always fits
  // 64 bits so the subtract can wrap at 64.
  always_comb begin
    trial  = {rem, quo[2*W-1]};
    q_bit  = (trial >= {1'b0, dabs});
    rem_nx = q_bit ? (trial[2*W-1:0] - dabs) : trial[2*W-1:0];
    quo_nx = {quo[2*W-2:0], q_bit};
    b_word = (n_neg ^ d_neg) ? (~quo_nx[W-1:0] + 1'b1) : quo_nx[W-1:0];
  end

  // Merge the finishing element's quotient into the result word.
  always_comb begin
    res_nx = res;
    case (el)
      2'd0:    res_nx[4*W-1:3*W] = b_word;
      2'd1:    res_nx[3*W-1:2*W] = b_word;
      2'd2:    res_nx[2*W-1:W]   = b_word;
      default: res_nx[W-1:0]     = b_word;
    endcase
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; a_q <= '0; c_q <= '0; res <= '0;
      det <= '0; num <= '0; dabs <= '0; quo <= '0; rem <= '0;
      d_neg <= 1'b0; n_neg <= 1'b0; inx_acc <= 1'b0; cnt <= '0; el <= '0;
      in_ready <= 1'b1; out_valid <= 1'b0; B <= '0;
      singular <= 1'b0; inexact <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_q <= A; c_q <= C; inx_acc <= 1'b0; el <= 2'd0; res <= '0;
          in_ready <= 1'b0;
          state <= S_DET0;
        end
        S_DET0: begin det <= prod; state <= S_DET1; end
        S_DET1: begin det <= det - prod; state <= S_CHK; end
        S_CHK: begin
          if (det == '0) begin
            B <= '0; singular <= 1'b1; inexact <= 1'b0;
            out_valid <= 1'b1;
            state <= S_DONE;
          end else begin
            dabs  <= det[2*W-1] ? -det : det;
            d_neg <= det[2*W-1];
            state <= S_MUL0;
          end
        end
        S_MUL0: begin num <= prod; state <= S_MUL1; end
        S_MUL1: begin
          num   <= num_nx;
          quo   <= num_nx[2*W-1] ? -num_nx : num_nx;
          n_neg <= num_nx[2*W-1];
          rem   <= '0;
          cnt   <= '0;
          state <= S_DIV;
        end
        S_DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd63) begin
            res     <= res_nx;
            inx_acc <= inx_acc | (rem_nx != '0);
            if (el == 2'd3) begin
              B <= res_nx; singular <= 1'b0;
              inexact <= inx_acc | (rem_nx != '0);
              out_valid <= 1'b1;
              state <= S_DONE;
            end else begin
              el    <= el + 2'd1;
              state <= S_MUL0;
            end
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_solve.sv
// Self-checking bench for mat_solve: fixed vectors, randomized solves
// against a longint reference model, backpressure and mid-op reset.
module tb_mat_solve;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] a_in;
  logic [127:0] c_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] b_out;
  logic         singular;
  logic         inexact;
  logic [2:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  mat_solve dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .A(a_in), .C(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .B(b_out),
    .singular(singular), .inexact(inexact), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: solve A*B = C with signed 64-bit arithmetic,
  // truncating division, low 32 bits of each quotient.
  function automatic void model(input logic [127:0] a, input logic [127:0] c,
                                output logic [127:0] b, output logic sing,
                                output logic inx);
    longint a00 = $signed(a[127:96]);
    longint a01 = $signed(a[95:64]);
    longint a10 = $signed(a[63:32]);
    longint a11 = $signed(a[31:0]);
    longint c00 = $signed(c[127:96]);
    longint c01 = $signed(c[95:64]);
    longint c10 = $signed(c[63:32]);
    longint c11 = $signed(c[31:0]);
    longint det, q;
    longint n[4];
    det  = a00 * a11 - a01 * a10;
    n[0] = a11 * c00 - a01 * c10;
    n[1] = a11 * c01 - a01 * c11;
    n[2] = a00 * c10 - a10 * c00;
    n[3] = a00 * c11 - a10 * c01;
    b = '0; sing = 1'b0; inx = 1'b0;
    if (det == 0) begin
      sing = 1'b1;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      q = n[i] / det;
      if (n[i] % det != 0) inx = 1'b1;
      b[(3-i)*32 +: 32] = q[31:0];
    end
  endfunction

  function automatic logic [127:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {x0, x1, x2, x3};
  endfunction

  function automatic int rand_elem();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 40)) - 20;
      1:       return int'($urandom_range(0, 200000)) - 100000;
      default: return int'($urandom);
    endcase
  endfunction

  // Driver: present A/C, wait for acceptance, then count edges until
  // out_valid. Leaves out_ready low so the result is held for checking.
  task automatic do_solve(input logic [127:0] a, input logic [127:0] c, output int lat);
    int guard;
    out_ready = 1'b0;
    a_in = a; c_in = c; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; c_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_tests++; if (b_out !== 128'd0) begin n_fail++; $display("FAIL reset_b got %h exp 0", b_out); end
    n_tests++; if (singular !== 1'b0 || inexact !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", singular, inexact); end
  endtask

  task automatic test_vector(input string name, input logic [127:0] a, input logic [127:0] c,
                             input logic [127:0] b_exp, input logic sing_exp, input logic inx_exp,
                             input int lat_exp);
    int lat;
    do_solve(a, c, lat);
    n_tests++; if (lat !== lat_exp) begin n_fail++; $display("FAIL %s_latency got %0d exp %0d", name, lat, lat_exp); end
    n_tests++; if (b_out !== b_exp) begin n_fail++; $display("FAIL %s_b got %h exp %h", name, b_out, b_exp); end
    n_tests++; if (singular !== sing_exp) begin n_fail++; $display("FAIL %s_singular got %b exp %b", name, singular, sing_exp); end
    n_tests++; if (inexact !== inx_exp) begin n_fail++; $display("FAIL %s_inexact got %b exp %b", name, inexact, inx_exp); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_in_ready_busy got %b exp 0", name, in_ready); end
    release_out();
  endtask

  task automatic test_fixed();
    test_vector("basic", pack4(2, 1, 1, 3), pack4(5, 8, 10, 14), pack4(1, 2, 3, 4), 1'b0, 1'b0, 267);
    test_vector("signs", pack4(-1, 0, 0, 1), pack4(7, -8, 9, 10), pack4(-7, 8, 9, 10), 1'b0, 1'b0, 267);
    test_vector("inexact", pack4(2, 0, 0, 2), pack4(3, 4, 5, -7), pack4(1, 2, 2, -3), 1'b0, 1'b1, 267);
    test_vector("singular", pack4(2, 4, 1, 2), pack4(9, -3, 77, 1), 128'd0, 1'b1, 1'b0, 3);
  endtask

  task automatic test_random();
    logic [127:0] a, c, b_exp;
    logic s_exp, i_exp;
    int lat;
    for (int k = 0; k < 20; k++) begin
      if (k % 5 == 4) begin
        int x = rand_elem() % 1000;
        int y = rand_elem() % 1000;
        int m = int'($urandom_range(0, 6)) - 3;
        a = pack4(x, y, x * m, y * m);
      end else begin
        a = pack4(rand_elem(), rand_elem(), rand_elem(), rand_elem());
      end
      c = pack4(rand_elem(), rand_elem(), rand_elem(), rand_elem());
      model(a, c, b_exp, s_exp, i_exp);
      do_solve(a, c, lat);
      n_tests++; if (lat !== (s_exp ? 3 : 267)) begin n_fail++; $display("FAIL rand%0d_latency got %0d exp %0d", k, lat, s_exp ? 3 : 267); end
      n_tests++; if (b_out !== b_exp || singular !== s_exp || inexact !== i_exp) begin
        n_fail++;
        $display("FAIL rand%0d_result got %h s%b i%b exp %h s%b i%b", k, b_out, singular, inexact, b_exp, s_exp, i_exp);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a1, c1, b1, a2, c2, b2;
    logic s1, i1, s2, i2;
    int lat;
    a1 = pack4(3, -2, 5, 7); c1 = pack4(100, -45, 13, 999);
    a2 = pack4(-9, 4, 6, 11); c2 = pack4(-500, 321, 77, -8);
    model(a1, c1, b1, s1, i1);
    model(a2, c2, b2, s2, i2);
    do_solve(a1, c1, lat);
    n_tests++; if (b_out !== b1 || inexact !== i1) begin n_fail++; $display("FAIL bp_first got %h i%b exp %h i%b", b_out, inexact, b1, i1); end
    for (int i = 0; i < 10; i++) begin
      in_valid = $urandom_range(0, 1);
      a_in = a2; c_in = c2;
      @(posedge clk); #1;
      n_tests++; if (b_out !== b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got b=%h ov=%b ir=%b exp b=%h ov=1 ir=0", i, b_out, out_valid, in_ready, b1);
      end
    end
    in_valid = 1'b0;
    release_out();
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); end
    n_tests++; if (b_out !== b1) begin n_fail++; $display("FAIL bp_b_after_release got %h exp %h", b_out, b1); end
    do_solve(a2, c2, lat);
    n_tests++; if (lat !== 267) begin n_fail++; $display("FAIL b2b_latency got %0d exp 267", lat); end
    n_tests++; if (b_out !== b2 || singular !== s2 || inexact !== i2) begin n_fail++; $display("FAIL b2b_result got %h i%b exp %h i%b", b_out, inexact, b2, i2); end
    release_out();
  endtask

  task automatic test_reset_midop();
    logic [127:0] a, c, b_exp;
    logic s_exp, i_exp;
    int lat;
    a = pack4(2, 1, 1, 3); c = pack4(5, 8, 10, 14);
    a_in = a; c_in = c; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_hs got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
    n_tests++; if (b_out !== 128'd0 || singular !== 1'b0 || inexact !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out got %h s%b i%b exp 0", b_out, singular, inexact); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    a = pack4(4, -3, 2, 5); c = pack4(17, -1, 60, 250);
    model(a, c, b_exp, s_exp, i_exp);
    do_solve(a, c, lat);
    n_tests++; if (lat !== 267) begin n_fail++; $display("FAIL rst_mid_latency got %0d exp 267", lat); end
    n_tests++; if (b_out !== b_exp || inexact !== i_exp) begin n_fail++; $display("FAIL rst_mid_result got %h i%b exp %h i%b", b_out, inexact, b_exp, i_exp); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
